servo_ramp_ctrl: RTL

- Command stage directly upstream of the servo PWM generator.
- Accepts target pulse-width commands over a valid/ready handshake and clamps them to the legal servo range.
- Owns the servo frame timebase.
- Slews the delivered pulse width toward the target by at most STEP per frame, updating only at frame boundaries, so the downstream generator never sees a mid-frame change.

---
 rtl/servo_ramp_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: command stage ahead of the servo PWM generator.
// Accepts pulse-width commands over valid/ready, clamps them to the legal
// servo range, owns the frame timebase, and slews the delivered pulse width
// toward the target by at most STEP per frame, changing only at frame ticks.
module servo_ramp_ctrl #(
  parameter int unsigned W            = 32,
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned MIN_PW       = 50000,
  parameter int unsigned MAX_PW       = 100000,
  parameter int unsigned STEP         = 500
) (
  input  logic         clock_clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [W-1:0] cmd_pw,
  output logic         cmd_ready,
  output logic [W-1:0] pw_out,
  output logic         frame_tick,
  output logic         cmd_clamped,
  output logic         busy,
  output logic         at_target
);

  localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYCLES - 1);
  localparam logic [W-1:0] MIN_W    = W'(MIN_PW);
  localparam logic [W-1:0] MAX_W    = W'(MAX_PW);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam logic [W-1:0] CENTER_W = W'((MIN_PW + MAX_PW) / 2);

  logic [W-1:0] frame_cnt_reg, frame_cnt_next;
  logic         frame_tick_reg;
  logic [W-1:0] pw_reg, pw_next;
  logic [W-1:0] target_reg;
  logic [W-1:0] pend_pw_reg;
  logic         pending_reg;
  logic         clamped_reg;

  logic         accept;
  logic         out_of_range;
  logic [W-1:0] clamped_pw;
  logic [W-1:0] next_target;
  logic [W-1:0] pw_diff;
  logic [W-1:0] pw_stepped;

  // Frame counter successor: wraps after the last clock of the frame.
  always_comb begin
    frame_cnt_next = frame_cnt_reg + W'(1);
    if (frame_cnt_reg == LAST_CNT) begin
      frame_cnt_next = '0;
    end
  end

  // Frame timebase; the tick is registered so it lines up with the counter's last value.
  always_ff @(posedge clock_clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg  <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_cnt_reg  <= frame_cnt_next;
      frame_tick_reg <= (frame_cnt_next == LAST_CNT);
    end
  end

  // Command acceptance and range clamping.
  always_comb begin
    accept       = cmd_valid && !pending_reg;
    out_of_range = (cmd_pw < MIN_W) || (cmd_pw > MAX_W);
    clamped_pw   = cmd_pw;
    if (cmd_pw < MIN_W) begin
      clamped_pw = MIN_W;
    end else if (cmd_pw > MAX_W) begin
      clamped_pw = MAX_W;
    end
  end

  // Slew computation: move toward the new target by at most STEP, no wrap.
  always_comb begin
    next_target = pending_reg ? pend_pw_reg : target_reg;
    if (next_target > pw_reg) begin
      pw_diff    = next_target - pw_reg;
      pw_stepped = pw_reg + STEP_W;
    end else begin
      pw_diff    = pw_reg - next_target;
      pw_stepped = pw_reg - STEP_W;
    end
    pw_next = (pw_diff <= STEP_W) ? next_target : pw_stepped;
  end

  // Pending command slot; an accept in a tick cycle survives that tick.
  always_ff @(posedge clock_clk or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
      pend_pw_reg <= CENTER_W;
      clamped_reg <= 1'b0;
    end else begin
      clamped_reg <= accept && out_of_range;
      if (frame_tick_reg) begin
        pending_reg <= 1'b0;
      end
      if (accept) begin
        pending_reg <= 1'b1;
        pend_pw_reg <= clamped_pw;
      end
    end
  end

  // Target and delivered pulse width update only at frame ticks.
  always_ff @(posedge clock_clk or posedge reset) begin
    if (reset) begin
      target_reg <= CENTER_W;
      pw_reg     <= CENTER_W;
    end else if (frame_tick_reg) begin
      target_reg <= next_target;
      pw_reg     <= pw_next;
    end
  end

  assign cmd_ready   = !pending_reg;
  assign pw_out      = pw_reg;
  assign frame_tick  = frame_tick_reg;
  assign cmd_clamped = clamped_reg;
  assign busy        = pending_reg || (pw_reg != target_reg);
  assign at_target   = !busy;

endmodule
